// File: rtl/cpu_defs_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, opcode constants and decoder control bit indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs_pkg;

    // Fetch FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    // Opcodes as seen in instr[31:26]
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    // Decoder control vector bit positions; the decoder uses the same indices
    localparam int CTRL_PCW  = 0;
    localparam int CTRL_PCWC = 1;
    localparam int CTRL_PC_S = 2;
    localparam int CTRL_W    = 3;

    // Branch displacement: sign-extended 16-bit word offset, scaled to bytes
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Jump target: region bits of the link address plus the 26-bit word index
    function automatic logic [31:0] jump_target(input logic [31:0] link,
                                                input logic [25:0] idx);
        return {link[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4, branch target or jump target from decoder control bits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when next_pc is consumed.
module pc_next
    import cpu_defs_pkg::*;
(
    input  logic [31:0]       pc,
    input  logic [25:0]       instr_lo,
    input  logic [CTRL_W-1:0] ctrl,
    input  logic              cond_met,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       next_pc
);

    logic        take;
    logic [31:0] br_tgt;
    logic [31:0] jump_tgt;

    // Target arithmetic wraps modulo 2^32; all targets stay word-aligned
    always_comb begin
        pc_plus4 = pc + 32'd4;
        br_tgt   = pc_plus4 + br_offset(instr_lo[15:0]);
        jump_tgt = jump_target(pc_plus4, instr_lo);
        take     = ctrl[CTRL_PCW] | (ctrl[CTRL_PCWC] & cond_met);
        next_pc  = pc_plus4;
        if (take) begin
            next_pc = ctrl[CTRL_PC_S] ? jump_tgt : br_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, fetches over req/ack, holds the word in an instruction register for the decoder.
// Latency: one idle cycle after reset, then >=1 cycle per fetch (ack in first request cycle) plus one hold cycle.
// Backpressure: instruction held with instr_valid until instr_ready; request held until imem_ack.
module fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        pc_src,
    input  logic        cond_met
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;

    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       next_pc;

    // Pack decoder bits into the shared control vector layout
    always_comb begin
        ctrl            = '0;
        ctrl[CTRL_PCW]  = pc_write;
        ctrl[CTRL_PCWC] = pc_write_cond;
        ctrl[CTRL_PC_S] = pc_src;
    end

    pc_next u_pc_next (
        .pc       (pc_q),
        .instr_lo (instr_q[25:0]),
        .ctrl     (ctrl),
        .cond_met (cond_met),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // Next-state logic; acks outside S_REQ and controls outside the retiring cycle are ignored
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d    = next_pc;
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from state and registers only, so valid never depends on ready
    always_comb begin
        imem_req    = (state_q == S_REQ);
        instr_valid = (state_q == S_HOLD);
        imem_addr   = pc_q;
        pc          = pc_q;
        instr       = instr_q;
        op          = instr_q[31:26];
    end

    // State, PC and instruction registers; reset discards any same-cycle ack or redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: instruction-level reference model with randomised memory latency and retire pressure.
// Latency: n/a.
// Backpressure: randomised instr_ready and ack delay.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_src;
    logic        cond_met;

    int tests;
    int fails;

    // Sparse overrides on top of a hashed background memory image
    logic [31:0] ovr [logic [31:0]];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .op            (op),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .cond_met      (cond_met)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Architectural next-PC rule written as plain arithmetic
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] w,
                                               input bit pw, input bit pwc, input bit src, input bit cm);
        logic [31:0] link;
        int          off;
        link = cur + 32'd4;
        if (!(pw || (pwc && cm))) return link;
        if (src) return (link & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
        off = int'($signed(w[15:0]));
        return link + 32'(off * 4);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        instr_ready   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        cond_met      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Serve the outstanding request immediately until the instruction is held
    task automatic fetch_to_hold(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            imem_ack   = imem_req;
            imem_rdata = mem_word(imem_addr);
            tick();
            imem_ack = 1'b0;
        end
        imem_ack = 1'b0;
    endtask

    task automatic retire(input bit pw, input bit pwc, input bit src, input bit cm);
        instr_ready   = 1'b1;
        pc_write      = pw;
        pc_write_cond = pwc;
        pc_src        = src;
        cond_met      = cm;
        tick();
        instr_ready   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        cond_met      = 1'b0;
    endtask

    task automatic check_hold_timeout(input string name, input bit ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: instr_valid not seen within budget (got 0, need 1)", name);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_ack    = 1'b1;
        instr_ready = 1'b1;
        imem_rdata  = 32'h0;
        do_reset();
        tests++;
        if ({imem_req, instr_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_ctrl: req/valid got %b, need 00", {imem_req, instr_valid});
        end
        tests++;
        if (pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc: got %h, need 00000000", pc);
        end
        tests++;
        if (instr !== 32'h0) begin
            fails++;
            $display("FAIL reset_instr: got %h, need 00000000", instr);
        end
    endtask

    // Ack and ready tied high: one retire every two cycles, sequential PCs
    task automatic test_sequential();
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (instr_valid !== (k % 2 == 0)) begin
                fails++;
                $display("FAIL seq_valid: cycle %0d got %b, need %b", k, instr_valid, (k % 2 == 0));
            end
            if (k % 2 == 0) begin
                tests++;
                if (pc !== 32'((k / 2 - 1) * 4) || instr !== 32'h0) begin
                    fails++;
                    $display("FAIL seq_pc: cycle %0d got pc=%h instr=%h, need pc=%h instr=0",
                             k, pc, instr, 32'((k / 2 - 1) * 4));
                end
            end
        end
        clear_inputs();
    endtask

    // Random ack latency, random ready and random controls against the model
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] w;
        logic [31:0] prev_addr;
        bit          prev_req;
        int          lat_left;
        int          retired;
        int          idle;
        bit          pw, pwc, src, cm;
        clear_inputs();
        ovr.delete();
        do_reset();
        exp_pc   = 32'h0;
        prev_req = 1'b0;
        prev_addr = 32'h0;
        lat_left = 0;
        retired  = 0;
        idle     = 0;
        while (retired < 40) begin
            if (imem_req) begin
                if (!prev_req) lat_left = int'($urandom_range(0, 3));
                tests++;
                if (imem_addr !== exp_pc) begin
                    fails++;
                    $display("FAIL rnd_addr: got %h, need %h", imem_addr, exp_pc);
                end
                if (prev_req) begin
                    tests++;
                    if (imem_addr !== prev_addr) begin
                        fails++;
                        $display("FAIL rnd_addr_stable: got %h, need %h", imem_addr, prev_addr);
                    end
                end
                if (lat_left == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(exp_pc);
                end else begin
                    lat_left--;
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                end
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                imem_rdata = $urandom;
            end
            prev_req  = imem_req;
            prev_addr = imem_addr;
            pw  = 1'($urandom_range(0, 1));
            pwc = 1'($urandom_range(0, 1));
            src = 1'($urandom_range(0, 1));
            cm  = 1'($urandom_range(0, 1));
            pc_write = pw; pc_write_cond = pwc; pc_src = src; cond_met = cm;
            instr_ready = 1'b0;
            if (instr_valid) begin
                w = mem_word(exp_pc);
                tests++;
                if (pc !== exp_pc || instr !== w || op !== w[31:26] || pc_plus4 !== exp_pc + 32'd4) begin
                    fails++;
                    $display("FAIL rnd_hold: got pc=%h instr=%h op=%h p4=%h, need pc=%h instr=%h",
                             pc, instr, op, pc_plus4, exp_pc, w);
                end
                instr_ready = 1'($urandom_range(0, 1));
                if (instr_ready) begin
                    exp_pc = model_next(exp_pc, w, pw, pwc, src, cm);
                    retired++;
                    idle = 0;
                end
            end
            idle++;
            if (idle > 30) begin
                tests++;
                fails++;
                $display("FAIL rnd_progress: no retire for %0d cycles, retired %0d of 40", idle, retired);
                break;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_jump();
        bit ok;
        clear_inputs();
        ovr.delete();
        ovr[32'h0] = 32'h0810_0004;
        do_reset();
        fetch_to_hold(ok);
        check_hold_timeout("jump_fetch", ok);
        tests++;
        if (op !== 6'h02) begin
            fails++;
            $display("FAIL jump_op: got %h, need 02", op);
        end
        retire(1'b1, 1'b0, 1'b1, 1'b0);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0010) begin
            fails++;
            $display("FAIL jump_target: got req=%b addr=%h, need req=1 addr=00400010", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        bit ok;
        clear_inputs();
        ovr.delete();
        ovr[32'h0]  = 32'h0800_0010;
        ovr[32'h40] = 32'h1000_FFFF;
        do_reset();
        fetch_to_hold(ok);
        retire(1'b1, 1'b0, 1'b1, 1'b0);
        fetch_to_hold(ok);
        check_hold_timeout("beq_fetch", ok);
        tests++;
        if (pc !== 32'h40 || instr !== 32'h1000_FFFF) begin
            fails++;
            $display("FAIL beq_at40: got pc=%h instr=%h, need pc=00000040 instr=1000ffff", pc, instr);
        end
        retire(1'b0, 1'b1, 1'b0, 1'b1);
        tests++;
        if (imem_addr !== 32'h40) begin
            fails++;
            $display("FAIL beq_taken: got %h, need 00000040", imem_addr);
        end
        fetch_to_hold(ok);
        retire(1'b0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (imem_addr !== 32'h44) begin
            fails++;
            $display("FAIL beq_not_taken: got %h, need 00000044", imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit ok;
        clear_inputs();
        ovr.delete();
        ovr[32'h0]  = 32'h0800_0020;
        ovr[32'h80] = 32'hDEAD_BEEF;
        do_reset();
        fetch_to_hold(ok);
        retire(1'b1, 1'b0, 1'b1, 1'b0);
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
            fails++;
            $display("FAIL rstmid_setup: got req=%b addr=%h, need req=1 addr=00000080", imem_req, imem_addr);
        end
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        rst = 1'b0;
        tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_ack_same: got req=%b valid=%b instr=%h pc=%h, need 0 0 0 0",
                     imem_req, instr_valid, instr, pc);
        end
        tick();
        imem_ack = 1'b0;
        tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr !== 32'h0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_ack_next: got req=%b addr=%h instr=%h valid=%b, need 1 0 0 0",
                     imem_req, imem_addr, instr, instr_valid);
        end
        fetch_to_hold(ok);
        check_hold_timeout("rstmid_refetch", ok);
        tests++;
        if (instr !== 32'h0800_0020 || pc !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_refetch_data: got instr=%h pc=%h, need 08000020 0", instr, pc);
        end
        // Reset while holding with a redirect pending
        rst = 1'b1;
        instr_ready = 1'b1;
        pc_write = 1'b1;
        pc_src = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        tests++;
        if (instr_valid !== 1'b0 || pc !== 32'h0 || imem_req !== 1'b0) begin
            fails++;
            $display("FAIL rsthold: got valid=%b pc=%h req=%b, need 0 0 0", instr_valid, pc, imem_req);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        clear_inputs();
        ovr.delete();
        ovr[32'h0] = 32'h1000_FFFE;
        do_reset();
        fetch_to_hold(ok);
        retire(1'b0, 1'b1, 1'b0, 1'b1);
        tests++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            fails++;
            $display("FAIL wrap_reach: got %h, need fffffffc", imem_addr);
        end
        fetch_to_hold(ok);
        check_hold_timeout("wrap_fetch", ok);
        tests++;
        if (pc_plus4 !== 32'h0) begin
            fails++;
            $display("FAIL wrap_pc_plus4: got %h, need 00000000", pc_plus4);
        end
        retire(1'b0, 1'b0, 1'b0, 1'b1);
        tests++;
        if (imem_addr !== 32'h0) begin
            fails++;
            $display("FAIL wrap_next: got %h, need 00000000", imem_addr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_random();
        test_jump();
        test_branch();
        test_reset_mid_fetch();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
